codificador_4a2_prioridad: RTL and testbench

- Registered 4-to-2 priority encoder with valid/ready handshake on both sides.
- Inverse of the team's 2-to-4 decoder: one-hot Entrada bit i produces Codigo = i, so decoder(codificador(x)) = x for every one-hot x.
- Sits between request/one-hot sources (buttons, arbiter grants, status lines) and binary consumers.
- Supports fixed priority and round-robin priority, and flags empty and multi-hot inputs.

---
 rtl/codificador_4a2_prioridad_pkg.sv | 16 +
 rtl/codificador_4a2_prioridad_if.sv | 24 ++
 rtl/codificador_4a2_prioridad_nucleo.sv | 43 ++++
 rtl/codificador_4a2_prioridad.sv | 66 ++++++
 tb/tb_codificador_4a2_prioridad.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/codificador_4a2_prioridad_pkg.sv
// Shared widths, priority-mode selectors and output payload for the 4-to-2 priority encoder.
package codificador_4a2_prioridad_pkg;

  localparam int unsigned ANCHO_ENTRADA = 4;
  localparam int unsigned ANCHO_CODIGO  = 2;

  localparam int unsigned PRIO_FIJA = 0;
  localparam int unsigned PRIO_RR   = 1;

  typedef struct packed {
    logic [ANCHO_CODIGO-1:0] codigo;
    logic                    ninguna;
    logic                    multiple;
  } salida_t;

endpackage

// File: rtl/codificador_4a2_prioridad_if.sv
// Request-side and result-side valid/ready bundle of the priority encoder.
interface codificador_4a2_prioridad_if;
  import codificador_4a2_prioridad_pkg::*;

  logic [ANCHO_ENTRADA-1:0] Entrada;
  logic                     EntradaValida;
  logic                     EntradaLista;
  logic [ANCHO_CODIGO-1:0]  Codigo;
  logic                     Ninguna;
  logic                     Multiple;
  logic                     SalidaValida;
  logic                     SalidaLista;

  modport master (
    output Entrada, EntradaValida, SalidaLista,
    input  EntradaLista, Codigo, Ninguna, Multiple, SalidaValida
  );

  modport slave (
    input  Entrada, EntradaValida, SalidaLista,
    output EntradaLista, Codigo, Ninguna, Multiple, SalidaValida
  );

endinterface

// File: rtl/codificador_4a2_prioridad_nucleo.sv
// Combinational priority search: fixed high/low priority or round-robin from Puntero.
module codificador_prioridad_nucleo
  import codificador_4a2_prioridad_pkg::*;
(
  input  logic [ANCHO_ENTRADA-1:0] Entrada,
  input  logic [ANCHO_CODIGO-1:0]  Puntero,
  input  logic                     ModoRr,
  input  logic                     PrioridadAlta,
  output logic [ANCHO_CODIGO-1:0]  Codigo,
  output logic                     Ninguna,
  output logic                     Multiple
);

  logic [2:0]              cuenta;
  logic [ANCHO_CODIGO-1:0] idx;

  // Each search loop runs from least to most preferred so the last hit wins.
  always_comb begin
    Codigo = '0;
    idx    = '0;
    cuenta = '0;
    for (int i = 0; i < int'(ANCHO_ENTRADA); i++) begin
      cuenta = cuenta + 3'(Entrada[i]);
    end
    if (ModoRr) begin
      for (int k = int'(ANCHO_ENTRADA) - 1; k >= 0; k--) begin
        idx = Puntero + ANCHO_CODIGO'(k);
        if (Entrada[idx]) Codigo = idx;
      end
    end else if (PrioridadAlta) begin
      for (int i = 0; i < int'(ANCHO_ENTRADA); i++) begin
        if (Entrada[i]) Codigo = ANCHO_CODIGO'(i);
      end
    end else begin
      for (int i = int'(ANCHO_ENTRADA) - 1; i >= 0; i--) begin
        if (Entrada[i]) Codigo = ANCHO_CODIGO'(i);
      end
    end
    Ninguna  = (Entrada == '0);
    Multiple = (cuenta > 3'd1);
  end

endmodule

// File: rtl/codificador_4a2_prioridad.sv
// Registered 4-to-2 priority encoder with a single skid-free output register and RR pointer.
module codificador_4a2_prioridad
  import codificador_4a2_prioridad_pkg::*;
#(
  parameter int unsigned MODO_RR        = PRIO_FIJA,
  parameter int unsigned PRIORIDAD_ALTA = 1
) (
  input logic                         Reloj,
  input logic                         ResetN,
  codificador_4a2_prioridad_if.slave  bus
);

  localparam logic MODO_RR_B   = (MODO_RR == PRIO_RR);
  localparam logic PRIO_ALTA_B = (PRIORIDAD_ALTA != 0);

  salida_t                 salida_q, salida_d, nueva;
  logic                    valida_q, valida_d;
  logic [ANCHO_CODIGO-1:0] puntero_q, puntero_d;
  logic                    aceptar, consumir;

  codificador_prioridad_nucleo u_nucleo (
    .Entrada       (bus.Entrada),
    .Puntero       (puntero_q),
    .ModoRr        (MODO_RR_B),
    .PrioridadAlta (PRIO_ALTA_B),
    .Codigo        (nueva.codigo),
    .Ninguna       (nueva.ninguna),
    .Multiple      (nueva.multiple)
  );

  assign bus.EntradaLista = ~valida_q | bus.SalidaLista;
  assign aceptar          = bus.EntradaValida & bus.EntradaLista;
  assign consumir         = valida_q & bus.SalidaLista;

  // Accept takes precedence over consume so back-to-back transfers keep SalidaValida high.
  always_comb begin
    salida_d  = salida_q;
    valida_d  = valida_q;
    puntero_d = puntero_q;
    if (aceptar) begin
      salida_d = nueva;
      valida_d = 1'b1;
      if (MODO_RR_B && !nueva.ninguna) puntero_d = nueva.codigo + ANCHO_CODIGO'(1);
    end else if (consumir) begin
      valida_d = 1'b0;
    end
  end

  always_ff @(posedge Reloj) begin
    if (!ResetN) begin
      salida_q  <= '0;
      valida_q  <= 1'b0;
      puntero_q <= '0;
    end else begin
      salida_q  <= salida_d;
      valida_q  <= valida_d;
      puntero_q <= puntero_d;
    end
  end

  assign bus.Codigo       = salida_q.codigo;
  assign bus.Ninguna      = salida_q.ninguna;
  assign bus.Multiple     = salida_q.multiple;
  assign bus.SalidaValida = valida_q;

endmodule

// File: tb/tb_codificador_4a2_prioridad.sv
// Directed bench for fixed-high, fixed-low and round-robin encoder instances.
module tb_codificador_4a2_prioridad;
  import codificador_4a2_prioridad_pkg::*;

  logic Reloj;
  logic ResetN;
  int   pruebas;
  int   fallos;

  codificador_4a2_prioridad_if bus_a ();
  codificador_4a2_prioridad_if bus_b ();
  codificador_4a2_prioridad_if bus_r ();

  codificador_4a2_prioridad #(.MODO_RR(PRIO_FIJA), .PRIORIDAD_ALTA(1)) u_alta (
    .Reloj(Reloj), .ResetN(ResetN), .bus(bus_a.slave));
  codificador_4a2_prioridad #(.MODO_RR(PRIO_FIJA), .PRIORIDAD_ALTA(0)) u_baja (
    .Reloj(Reloj), .ResetN(ResetN), .bus(bus_b.slave));
  codificador_4a2_prioridad #(.MODO_RR(PRIO_RR), .PRIORIDAD_ALTA(1)) u_rr (
    .Reloj(Reloj), .ResetN(ResetN), .bus(bus_r.slave));

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  task automatic ciclo;
    @(negedge Reloj);
  endtask

  task automatic test_reset;
    ResetN = 1'b0;
    ciclo(); ciclo();
    pruebas++; if (bus_a.SalidaValida !== 1'b0) begin fallos++; $display("FAIL reset_valida_a: got %b want 0", bus_a.SalidaValida); end
    pruebas++; if (bus_a.Codigo !== 2'd0) begin fallos++; $display("FAIL reset_codigo_a: got %0d want 0", bus_a.Codigo); end
    pruebas++; if ({bus_a.Ninguna, bus_a.Multiple} !== 2'b00) begin fallos++; $display("FAIL reset_flags_a: got %b want 00", {bus_a.Ninguna, bus_a.Multiple}); end
    pruebas++; if (bus_r.SalidaValida !== 1'b0) begin fallos++; $display("FAIL reset_valida_r: got %b want 0", bus_r.SalidaValida); end
    pruebas++; if (bus_a.EntradaLista !== 1'b1) begin fallos++; $display("FAIL reset_lista_a: got %b want 1", bus_a.EntradaLista); end
    ResetN = 1'b1;
  endtask

  task automatic test_barrido;
    logic [3:0] vec;
    logic [3:0] dec;
    bus_a.SalidaLista = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec = 4'b0001 << i;
      bus_a.Entrada = vec; bus_a.EntradaValida = 1'b1;
      ciclo();
      dec = 4'b0001 << bus_a.Codigo;
      pruebas++; if (bus_a.Codigo !== 2'(i)) begin fallos++; $display("FAIL barrido_codigo[%0d]: got %0d want %0d", i, bus_a.Codigo, i); end
      pruebas++; if ({bus_a.SalidaValida, bus_a.Ninguna, bus_a.Multiple} !== 3'b100) begin fallos++; $display("FAIL barrido_flags[%0d]: got %b want 100", i, {bus_a.SalidaValida, bus_a.Ninguna, bus_a.Multiple}); end
      pruebas++; if (dec !== vec) begin fallos++; $display("FAIL barrido_decodificado[%0d]: got %b want %b", i, dec, vec); end
    end
    bus_a.EntradaValida = 1'b0;
    ciclo();
    pruebas++; if (bus_a.SalidaValida !== 1'b0) begin fallos++; $display("FAIL barrido_fin_valida: got %b want 0", bus_a.SalidaValida); end
    pruebas++; if (bus_a.Codigo !== 2'd3) begin fallos++; $display("FAIL barrido_fin_codigo: got %0d want 3", bus_a.Codigo); end
  endtask

  task automatic test_prioridad_fija;
    logic [3:0] vecs [3];
    logic [1:0] esp_a [3];
    logic [1:0] esp_b [3];
    logic [1:0] esp_f [3];
    vecs  = '{4'b0110, 4'b0000, 4'b1011};
    esp_a = '{2'd2, 2'd0, 2'd3};
    esp_b = '{2'd1, 2'd0, 2'd0};
    esp_f = '{2'b01, 2'b10, 2'b01};
    bus_a.SalidaLista = 1'b1; bus_b.SalidaLista = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.Entrada = vecs[i]; bus_a.EntradaValida = 1'b1;
      bus_b.Entrada = vecs[i]; bus_b.EntradaValida = 1'b1;
      ciclo();
      pruebas++; if (bus_a.Codigo !== esp_a[i]) begin fallos++; $display("FAIL fija_alta_codigo[%0d]: got %0d want %0d", i, bus_a.Codigo, esp_a[i]); end
      pruebas++; if (bus_b.Codigo !== esp_b[i]) begin fallos++; $display("FAIL fija_baja_codigo[%0d]: got %0d want %0d", i, bus_b.Codigo, esp_b[i]); end
      pruebas++; if ({bus_a.Ninguna, bus_a.Multiple} !== esp_f[i]) begin fallos++; $display("FAIL fija_alta_flags[%0d]: got %b want %b", i, {bus_a.Ninguna, bus_a.Multiple}, esp_f[i]); end
      pruebas++; if ({bus_b.Ninguna, bus_b.Multiple} !== esp_f[i]) begin fallos++; $display("FAIL fija_baja_flags[%0d]: got %b want %b", i, {bus_b.Ninguna, bus_b.Multiple}, esp_f[i]); end
    end
    bus_a.EntradaValida = 1'b0; bus_b.EntradaValida = 1'b0;
    ciclo();
  endtask

  task automatic test_round_robin;
    logic [3:0] vecs [9];
    logic [1:0] esp_c [9];
    logic [1:0] esp_f [9];
    vecs  = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0011, 4'b1000};
    esp_c = '{2'd0,    2'd1,    2'd2,    2'd3,    2'd0,    2'd0,    2'd1,    2'd0,    2'd3};
    esp_f = '{2'b01,   2'b01,   2'b01,   2'b01,   2'b01,   2'b10,   2'b01,   2'b01,   2'b00};
    bus_r.SalidaLista = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_r.Entrada = vecs[i]; bus_r.EntradaValida = 1'b1;
      ciclo();
      pruebas++; if (bus_r.Codigo !== esp_c[i]) begin fallos++; $display("FAIL rr_codigo[%0d]: got %0d want %0d", i, bus_r.Codigo, esp_c[i]); end
      pruebas++; if ({bus_r.SalidaValida, bus_r.Ninguna, bus_r.Multiple} !== {1'b1, esp_f[i]}) begin fallos++; $display("FAIL rr_flags[%0d]: got %b want 1%b", i, {bus_r.SalidaValida, bus_r.Ninguna, bus_r.Multiple}, esp_f[i]); end
    end
    bus_r.EntradaValida = 1'b0;
    ciclo();
  endtask

  task automatic test_contrapresion;
    bus_a.SalidaLista = 1'b1; bus_a.Entrada = 4'b0100; bus_a.EntradaValida = 1'b1;
    ciclo();
    pruebas++; if (bus_a.Codigo !== 2'd2) begin fallos++; $display("FAIL bp_carga: got %0d want 2", bus_a.Codigo); end
    bus_a.SalidaLista = 1'b0; bus_a.Entrada = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      pruebas++; if (bus_a.EntradaLista !== 1'b0) begin fallos++; $display("FAIL bp_lista[%0d]: got %b want 0", i, bus_a.EntradaLista); end
      ciclo();
      pruebas++; if ({bus_a.SalidaValida, bus_a.Codigo} !== {1'b1, 2'd2}) begin fallos++; $display("FAIL bp_estable[%0d]: got %b want 110", i, {bus_a.SalidaValida, bus_a.Codigo}); end
      bus_a.Entrada = (i == 0) ? 4'b0001 : 4'b1000;
    end
    bus_a.SalidaLista = 1'b1;
    #1;
    pruebas++; if (bus_a.EntradaLista !== 1'b1) begin fallos++; $display("FAIL bp_lista_libre: got %b want 1", bus_a.EntradaLista); end
    ciclo();
    pruebas++; if ({bus_a.SalidaValida, bus_a.Codigo} !== {1'b1, 2'd3}) begin fallos++; $display("FAIL bp_consumo_carga: got %b want 111", {bus_a.SalidaValida, bus_a.Codigo}); end
    bus_a.EntradaValida = 1'b0;
    ciclo();
  endtask

  task automatic test_reset_intermedio;
    bus_r.SalidaLista = 1'b1; bus_r.Entrada = 4'b0010; bus_r.EntradaValida = 1'b1;
    ciclo();
    pruebas++; if ({bus_r.SalidaValida, bus_r.Codigo} !== {1'b1, 2'd1}) begin fallos++; $display("FAIL rst_med_previo: got %b want 101", {bus_r.SalidaValida, bus_r.Codigo}); end
    bus_r.EntradaValida = 1'b0; ResetN = 1'b0;
    ciclo();
    pruebas++; if ({bus_r.SalidaValida, bus_r.Codigo, bus_r.Ninguna, bus_r.Multiple} !== 5'b0) begin fallos++; $display("FAIL rst_med_borrado: got %b want 00000", {bus_r.SalidaValida, bus_r.Codigo, bus_r.Ninguna, bus_r.Multiple}); end
    ResetN = 1'b1; bus_r.Entrada = 4'b1111; bus_r.EntradaValida = 1'b1;
    ciclo();
    pruebas++; if (bus_r.Codigo !== 2'd0) begin fallos++; $display("FAIL rst_med_puntero: got %0d want 0", bus_r.Codigo); end
  endtask

  task automatic test_espera;
    bus_r.SalidaLista = 1'b1; bus_r.Entrada = 4'b0100; bus_r.EntradaValida = 1'b1;
    ciclo();
    pruebas++; if (bus_r.Codigo !== 2'd2) begin fallos++; $display("FAIL espera_carga: got %0d want 2", bus_r.Codigo); end
    bus_r.EntradaValida = 1'b0; bus_r.Entrada = 4'b0001;
    ciclo();
    pruebas++; if ({bus_r.SalidaValida, bus_r.Codigo} !== {1'b0, 2'd2}) begin fallos++; $display("FAIL espera_retencion: got %b want 010", {bus_r.SalidaValida, bus_r.Codigo}); end
    ciclo();
    bus_r.Entrada = 4'b1111; bus_r.EntradaValida = 1'b1;
    ciclo();
    pruebas++; if (bus_r.Codigo !== 2'd3) begin fallos++; $display("FAIL espera_puntero: got %0d want 3", bus_r.Codigo); end
    bus_r.EntradaValida = 1'b0;
    ciclo();
  endtask

  initial begin
    pruebas = 0;
    fallos  = 0;
    ResetN  = 1'b0;
    bus_a.Entrada = '0; bus_a.EntradaValida = 1'b0; bus_a.SalidaLista = 1'b0;
    bus_b.Entrada = '0; bus_b.EntradaValida = 1'b0; bus_b.SalidaLista = 1'b0;
    bus_r.Entrada = '0; bus_r.EntradaValida = 1'b0; bus_r.SalidaLista = 1'b0;
    test_reset();
    test_barrido();
    test_prioridad_fija();
    test_round_robin();
    test_contrapresion();
    test_reset_intermedio();
    test_espera();
    $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
    $finish;
  end

endmodule
